// File: rtl/rv32_decode_pipe.sv
// RV32I/M decode stage: valid/ready on both sides, registered output bundle
// backed by a one-entry skid buffer holding the raw instruction and pc.
module rv32_decode_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_BITS = 5,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned LINK_ALT = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         instruction_i,
  input  logic [XLEN-1:0]     pc_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [3:0]          alu_operation_o,
  output logic [2:0]          word_size_o,
  output logic [REG_BITS-1:0] rs1_addr_o,
  output logic [REG_BITS-1:0] rs2_addr_o,
  output logic [REG_BITS-1:0] rd_addr_o,
  output logic [XLEN-1:0]     immediate_o,
  output logic                immediate_valid_o,
  output logic [XLEN-1:0]     pc_o,
  output logic [2:0]          stage4_path_o,
  output logic                memory_write_o,
  output logic                memory_read_o,
  output logic                branch_o,
  output logic [2:0]          branch_condition_o,
  output logic                jal_o,
  output logic [XLEN-1:0]     jal_target_o,
  output logic                jalr_o,
  output logic                link_o,
  output logic [XLEN-1:0]     link_data_o,
  output logic                mret_o,
  output logic                illegal_o,
  output logic                push_ras_o,
  output logic                pop_ras_o
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("rv32_decode_pipe: only XLEN=32 is supported");
  end

  localparam logic [2:0] PATH_ALU = 3'b001;
  localparam logic [2:0] PATH_MEM = 3'b010;
  localparam logic [2:0] PATH_MUL = 3'b100;

  typedef struct packed {
    logic [3:0]          alu_op;
    logic [2:0]          word_size;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [REG_BITS-1:0] rd;
    logic [XLEN-1:0]     imm;
    logic                imm_valid;
    logic [XLEN-1:0]     pc;
    logic [2:0]          path;
    logic                mem_wr;
    logic                mem_rd;
    logic                branch;
    logic [2:0]          br_cond;
    logic                jal;
    logic [XLEN-1:0]     jal_target;
    logic                jalr;
    logic                link;
    logic [XLEN-1:0]     link_data;
    logic                mret;
    logic                illegal;
    logic                push_ras;
    logic                pop_ras;
  } bundle_t;

  // Pure decode of one instruction word; illegal encodings collapse to a flag-only bundle.
  function automatic bundle_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    bundle_t             b;
    logic [6:0]          f7;
    logic [2:0]          f3;
    logic [4:0]          opc;
    logic [REG_BITS-1:0] rd, rs1, rs2;
    logic [XLEN-1:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    logic                ill, rd_link, rs1_link;
    b     = '0;
    ill   = 1'b0;
    f7    = ins[31:25];
    f3    = ins[14:12];
    opc   = ins[6:2];
    rd    = REG_BITS'(ins[11:7]);
    rs1   = REG_BITS'(ins[19:15]);
    rs2   = REG_BITS'(ins[24:20]);
    imm_i = XLEN'({{20{ins[31]}}, ins[31:20]});
    imm_s = XLEN'({{20{ins[31]}}, ins[31:25], ins[11:7]});
    imm_b = XLEN'({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
    imm_u = XLEN'({ins[31:12], 12'b0});
    imm_j = XLEN'({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
    rd_link  = (rd == REG_BITS'(1)) || (rd == REG_BITS'(LINK_ALT));
    rs1_link = (rs1 == REG_BITS'(1)) || (rs1 == REG_BITS'(LINK_ALT));
    b.pc         = pc;
    b.path       = PATH_ALU;
    b.link_data  = pc + XLEN'(4);
    b.jal_target = pc + imm_j;
    if (ins[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opc)
        5'b01100: begin // OP
          b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
          b.alu_op = {f7[5], f3};
          if (f7 == 7'b0000001) begin
            if (ENABLE_M) b.path = PATH_MUL;
            else          ill = 1'b1;
          end else if (f7 == 7'b0100000) begin
            if (f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
          end else if (f7 != 7'b0) begin
            ill = 1'b1;
          end
        end
        5'b00100: begin // OP-IMM
          b.rd = rd; b.rs1 = rs1; b.imm = imm_i; b.imm_valid = 1'b1;
          b.alu_op = {(f3 == 3'b101) & f7[5], f3};
          if (f3 == 3'b001 && f7 != 7'b0) ill = 1'b1;
          if (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000) ill = 1'b1;
        end
        5'b00000: begin // LOAD
          b.rd = rd; b.rs1 = rs1; b.imm = imm_i; b.imm_valid = 1'b1;
          b.path = PATH_MEM; b.mem_rd = 1'b1; b.word_size = f3;
          if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
        end
        5'b01000: begin // STORE
          b.rs1 = rs1; b.rs2 = rs2; b.imm = imm_s; b.imm_valid = 1'b1;
          b.path = PATH_MEM; b.mem_wr = 1'b1; b.word_size = f3;
          if (f3 >= 3'b011) ill = 1'b1;
        end
        5'b11000: begin // BRANCH
          b.rs1 = rs1; b.rs2 = rs2; b.imm = imm_b;
          b.branch = 1'b1; b.br_cond = f3;
          if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
        end
        5'b11011: begin // JAL
          b.rd = rd; b.imm = imm_j; b.imm_valid = 1'b1;
          b.jal = 1'b1; b.link = (rd != '0); b.push_ras = rd_link;
        end
        5'b11001: begin // JALR
          b.rd = rd; b.rs1 = rs1; b.imm = imm_i; b.imm_valid = 1'b1;
          b.jalr = 1'b1; b.link = (rd != '0); b.push_ras = rd_link;
          b.pop_ras = rs1_link & (~rd_link | (rd != rs1));
        end
        5'b01101: begin // LUI
          b.rd = rd; b.imm = imm_u; b.imm_valid = 1'b1;
        end
        5'b00101: begin // AUIPC
          b.rd = rd; b.imm = imm_u + pc; b.imm_valid = 1'b1;
        end
        5'b00011: begin // FENCE as NOP
          b.imm = imm_i; b.imm_valid = 1'b1;
        end
        5'b11100: begin // SYSTEM: only MRET
          if (f3 == 3'b000 && ins[31:20] == 12'h302) begin
            b.mret = 1'b1; b.imm = imm_i; b.imm_valid = 1'b1;
          end else begin
            ill = 1'b1;
          end
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      b         = '0;
      b.pc      = pc;
      b.path    = PATH_ALU;
      b.illegal = 1'b1;
    end
    return b;
  endfunction

  bundle_t             out_q, out_d, dec_c;
  logic                out_valid_q, out_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic [31:0]         skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]     skid_pc_q, skid_pc_d;
  logic                in_ready_q, in_ready_d;
  logic                accept_c, out_free_c;

  // Single decoder: skid entry is older, so it has priority over the input port.
  assign dec_c = decode(skid_valid_q ? skid_instr_q : instruction_i,
                        skid_valid_q ? skid_pc_q    : pc_i);

  assign accept_c   = in_valid_i & in_ready_q;
  assign out_free_c = ~out_valid_q | out_ready_i;

  // Output register / skid next state; an empty output slot is all-zero so flags read 0.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush_i) begin
      out_d        = '0;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free_c) begin
      if (skid_valid_q | accept_c) begin
        out_d        = dec_c;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_d       = '0;
        out_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_valid_d = 1'b1;
      skid_instr_d = instruction_i;
      skid_pc_d    = pc_i;
    end
    in_ready_d = ~skid_valid_d;
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o         = in_ready_q;
  assign out_valid_o        = out_valid_q;
  assign alu_operation_o    = out_q.alu_op;
  assign word_size_o        = out_q.word_size;
  assign rs1_addr_o         = out_q.rs1;
  assign rs2_addr_o         = out_q.rs2;
  assign rd_addr_o          = out_q.rd;
  assign immediate_o        = out_q.imm;
  assign immediate_valid_o  = out_q.imm_valid;
  assign pc_o               = out_q.pc;
  assign stage4_path_o      = out_q.path;
  assign memory_write_o     = out_q.mem_wr;
  assign memory_read_o      = out_q.mem_rd;
  assign branch_o           = out_q.branch;
  assign branch_condition_o = out_q.br_cond;
  assign jal_o              = out_q.jal;
  assign jal_target_o       = out_q.jal_target;
  assign jalr_o             = out_q.jalr;
  assign link_o             = out_q.link;
  assign link_data_o        = out_q.link_data;
  assign mret_o             = out_q.mret;
  assign illegal_o          = out_q.illegal;
  assign push_ras_o         = out_q.push_ras;
  assign pop_ras_o          = out_q.pop_ras;

endmodule
